// File: rtl/micro_engine.sv
// Microprogrammed arithmetic engine: ACC + register file + ALU + 1-bit shifter, valid/ready streams.
// Optional 4-entry return stack for CALL/RET is enabled by defining MICRO_STACK_EN.
module micro_engine #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 8,
  parameter int UC_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             uc_we,
  input  logic [7:0]       uc_addr,
  input  logic [31:0]      uc_wdata,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int PCW = (UC_DEPTH > 1) ? $clog2(UC_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]      ucode [UC_DEPTH];
  logic [PCW-1:0]   pc, pc_nxt, pc_inc, tgt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] regs [NREGS];

  logic [31:0] uw;
  logic [3:0]  f_alu, f_src, f_dest;
  logic [2:0]  f_shft, f_seq;
  logic [7:0]  f_tgt;
  logic [31:0] tgt_mod;
  logic        unused_bits;

  assign uw     = ucode[pc];
  assign f_alu  = uw[31:28];
  assign f_shft = uw[27:25];
  assign f_src  = uw[24:21];
  assign f_dest = uw[20:17];
  assign f_seq  = uw[16:14];
  assign f_tgt  = uw[7:0];

  assign tgt_mod     = {24'd0, f_tgt} % 32'(UC_DEPTH);
  assign tgt         = tgt_mod[PCW-1:0];
  assign pc_inc      = (pc == PCW'(UC_DEPTH - 1)) ? '0 : pc + PCW'(1);
  assign unused_bits = ^{uw[13:8], tgt_mod};

  logic             in_stall, out_stall, exec_ok;
  logic [WIDTH-1:0] b_bus, alu_r, res;
  logic             alu_c, res_c;

  assign in_stall  = (f_src == 4'd15) && !din_valid;
  assign out_stall = (f_dest == 4'd15) && dout_valid && !dout_ready;
  assign exec_ok   = (state == S_EXEC) && !in_stall && !out_stall;
  assign din_ready = (state == S_EXEC) && (f_src == 4'd15) && !out_stall;
  assign busy      = (state == S_EXEC);
  assign halted    = (state == S_HALTED);

  always_comb begin
    b_bus = '0;
    if (f_src == 4'd15) begin
      b_bus = din;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (f_src == i[3:0]) b_bus = regs[i];
      end
    end
  end

  always_comb begin
    alu_r = b_bus;
    alu_c = 1'b0;
    case (f_alu)
      4'd1:    {alu_c, alu_r} = {1'b0, acc} + {1'b0, b_bus};
      4'd2: begin
        alu_r = acc - b_bus;
        alu_c = (acc < b_bus);
      end
      4'd3:    alu_r = acc & b_bus;
      4'd4:    alu_r = acc | b_bus;
      4'd5:    alu_r = acc ^ b_bus;
      4'd6:    alu_r = ~b_bus;
      4'd7:    alu_r = b_bus + WIDTH'(1);
      default: alu_r = b_bus;
    endcase
  end

  // Single-position shift; the bit pushed out replaces the ALU carry.
  always_comb begin
    res   = alu_r;
    res_c = alu_c;
    case (f_shft)
      3'd1: begin res = {alu_r[WIDTH-2:0], 1'b0};           res_c = alu_r[WIDTH-1]; end
      3'd2: begin res = {1'b0, alu_r[WIDTH-1:1]};           res_c = alu_r[0];       end
      3'd3: begin res = {alu_r[WIDTH-2:0], alu_r[WIDTH-1]}; res_c = alu_r[WIDTH-1]; end
      3'd4: begin res = {alu_r[0], alu_r[WIDTH-1:1]};       res_c = alu_r[0];       end
      3'd5: begin res = {alu_r[WIDTH-1], alu_r[WIDTH-1:1]}; res_c = alu_r[0];       end
      default: ;
    endcase
  end

`ifdef MICRO_STACK_EN
  logic [PCW-1:0] stk [4];
  logic [2:0]     sp;
  logic           err_q;
  logic           stk_push, stk_pop, stk_err;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
`ifdef MICRO_STACK_EN
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_err   = 1'b0;
`endif
    case (state)
      S_EXEC: begin
        if (exec_ok) begin
          pc_nxt = pc_inc;
          case (f_seq)
            3'd1: pc_nxt = tgt;
            3'd2: if (flag_z) pc_nxt = tgt;
            3'd3: if (flag_c) pc_nxt = tgt;
            3'd4: state_nxt = S_HALTED;
`ifdef MICRO_STACK_EN
            3'd5: begin
              if (sp == 3'd4) begin
                stk_err   = 1'b1;
                state_nxt = S_HALTED;
              end else begin
                stk_push = 1'b1;
                pc_nxt   = tgt;
              end
            end
            3'd6: begin
              if (sp == 3'd0) begin
                stk_err   = 1'b1;
                state_nxt = S_HALTED;
              end else begin
                stk_pop = 1'b1;
                pc_nxt  = stk[sp[1:0] - 2'd1];
              end
            end
`endif
            default: ;
          endcase
        end
      end
      default: begin
        if (start) begin
          state_nxt = S_EXEC;
          pc_nxt    = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      acc        <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (exec_ok) begin
        acc    <= res;
        flag_z <= (res == '0);
        flag_c <= res_c;
        for (int i = 0; i < NREGS; i++) begin
          if (f_dest == i[3:0]) regs[i] <= res;
        end
      end
      // A fresh OUT word replaces the one being accepted in the same cycle.
      if (exec_ok && (f_dest == 4'd15)) begin
        dout       <= res;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

`ifdef MICRO_STACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp    <= '0;
      err_q <= 1'b0;
    end else begin
      if (start && (state != S_EXEC)) begin
        sp    <= '0;
        err_q <= 1'b0;
      end else begin
        if (stk_push) sp <= sp + 3'd1;
        if (stk_pop)  sp <= sp - 3'd1;
        if (stk_err)  err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (stk_push) stk[sp[1:0]] <= pc_inc;
  end
`endif

  // Microcode store survives reset; writes are locked out while a program runs.
  always_ff @(posedge clk) begin
    if (uc_we && (state != S_EXEC) && ({24'd0, uc_addr} < 32'(UC_DEPTH)))
      ucode[uc_addr[PCW-1:0]] <= uc_wdata;
  end

endmodule

// File: tb/tb_micro_engine.sv
// Directed bench for micro_engine: per-scenario tasks with hand-computed expectations.
module tb_micro_engine;

  logic        clk, rst, start, uc_we;
  logic [7:0]  uc_addr;
  logic [31:0] uc_wdata;
  logic [15:0] din, dout;
  logic        din_valid, din_ready, dout_valid, dout_ready;
  logic        busy, halted, err, flag_z, flag_c;

  int errors = 0;
  int checks = 0;

  logic [15:0] din_q[$];
  logic [15:0] out_q[$];
  logic [31:0] prog[$];

  localparam logic [3:0] A_PASS = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3,
                         A_XOR = 4'd5, A_NOT = 4'd6, A_INC = 4'd7;
  localparam logic [2:0] SH_NO = 3'd0, SH_SHR = 3'd2, SH_ROL = 3'd3, SH_ASR = 3'd5;
  localparam logic [2:0] Q_NEXT = 3'd0, Q_JMP = 3'd1, Q_JC = 3'd3, Q_HALT = 3'd4,
                         Q_CALL = 3'd5, Q_RET = 3'd6;
  localparam logic [3:0] R_ZERO = 4'd13, R_ACC = 4'd14, R_IO = 4'd15;

  micro_engine #(.WIDTH(16), .NREGS(8), .UC_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .uc_we(uc_we), .uc_addr(uc_addr),
    .uc_wdata(uc_wdata), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
    .halted(halted), .err(err), .flag_z(flag_z), .flag_c(flag_c)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    din = '0; din_valid = 0;
    forever begin
      @(negedge clk);
      if (din_q.size() > 0) begin din = din_q[0]; din_valid = 1; end
      else din_valid = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    if (!rst && din_valid && din_ready && din_q.size() > 0) void'(din_q.pop_front());
    if (!rst && dout_valid && dout_ready) out_q.push_back(dout);
  end

  function automatic logic [31:0] mw(input logic [3:0] alu, input logic [2:0] sh,
                                     input logic [3:0] src, input logic [3:0] dst,
                                     input logic [2:0] seq, input logic [7:0] tgt);
    return {alu, sh, src, dst, seq, 6'd0, tgt};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; uc_we = 0; dout_ready = 1;
    din_q.delete(); out_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic load_prog();
    foreach (prog[i]) begin
      @(negedge clk);
      uc_we = 1; uc_addr = 8'(i); uc_wdata = prog[i];
    end
    @(negedge clk);
    uc_we = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL %s_timeout: halted=%b expected 1", name, halted); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if ({din_ready, dout_valid, busy, halted, err, flag_z, flag_c} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000",
                         {din_ready, dout_valid, busy, halted, err, flag_z, flag_c});
    end
    checks++;
    if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", dout); end
    do_reset();
    checks++;
    if ({busy, halted} !== 2'b00) begin errors++; $display("FAIL reset_idle: busy/halted=%b expected 00", {busy, halted}); end
  endtask

  task automatic test_add();
    do_reset();
    prog = '{mw(A_PASS, SH_NO, R_IO, R_ACC, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_IO, R_IO, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_HALT, 0)};
    load_prog();
    din_q = '{16'h1234, 16'h0001};
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL add_busy: got %b expected 1", busy); end
    wait_halted("add", 20);
    @(negedge clk);
    checks++;
    if (out_q.size() != 1 || out_q[0] !== 16'h1235) begin
      errors++; $display("FAIL add_out: got n=%0d first=%h expected n=1 1235", out_q.size(), (out_q.size() > 0) ? out_q[0] : 16'hxxxx);
    end
    checks++;
    if (dout !== 16'h1235) begin errors++; $display("FAIL add_dout: got %h expected 1235", dout); end
    checks++;
    if ({flag_c, busy, err} !== 3'b000) begin errors++; $display("FAIL add_state: c/busy/err=%b expected 000", {flag_c, busy, err}); end
  endtask

  task automatic test_carry_jump();
    do_reset();
    prog = '{mw(A_PASS, SH_NO, R_IO, R_ACC, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_IO, R_ACC, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_JC, 8'd69),
             mw(A_NOT, SH_NO, R_ZERO, R_IO, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_HALT, 0),
             mw(A_ADD, SH_NO, R_ZERO, R_IO, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_HALT, 0)};
    load_prog();
    din_q = '{16'hFFFF, 16'h0001};
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({flag_z, flag_c} !== 2'b11) begin errors++; $display("FAIL jc_flags: z/c=%b expected 11", {flag_z, flag_c}); end
    wait_halted("jc", 20);
    @(negedge clk);
    checks++;
    if (out_q.size() != 1 || out_q[0] !== 16'h0000) begin
      errors++; $display("FAIL jc_taken: got n=%0d first=%h expected n=1 0000", out_q.size(), (out_q.size() > 0) ? out_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_out_stall();
    do_reset();
    prog = '{mw(A_PASS, SH_NO, R_IO, R_IO, Q_NEXT, 0),
             mw(A_PASS, SH_NO, R_IO, R_IO, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_HALT, 0)};
    load_prog();
    din_q = '{16'h00A1, 16'h00B2};
    dout_ready = 0;
    pulse_start();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({dout, dout_valid, din_ready, busy} !== {16'h00A1, 3'b101}) begin
        errors++; $display("FAIL stall_hold%0d: dout=%h v/rdy/busy=%b expected 00a1 101", i, dout, {dout_valid, din_ready, busy});
      end
      @(negedge clk);
    end
    dout_ready = 1;
    @(negedge clk);
    checks++;
    if ({dout, dout_valid, halted} !== {16'h00B2, 2'b10}) begin
      errors++; $display("FAIL stall_release: dout=%h v/halt=%b expected 00b2 10", dout, {dout_valid, halted});
    end
    @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL stall_next_issue: halted=%b expected 1", halted); end
    checks++;
    if (out_q.size() != 2 || out_q[0] !== 16'h00A1 || out_q[1] !== 16'h00B2) begin
      errors++; $display("FAIL stall_seq: got n=%0d expected 00a1,00b2", out_q.size());
    end
  endtask

  task automatic test_in_stall();
    do_reset();
    prog = '{mw(A_PASS, SH_NO, R_IO, R_ACC, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_IO, R_IO, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_HALT, 0)};
    load_prog();
    din_q = '{16'h0011};
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({din_ready, din_valid, busy, dut.pc, dut.acc} !== {3'b101, 6'd1, 16'h0011}) begin
        errors++; $display("FAIL install_hold%0d: rdy/v/busy=%b pc=%0d acc=%h expected 101 1 0011",
                           i, {din_ready, din_valid, busy}, dut.pc, dut.acc);
      end
    end
    #1 din_q.push_back(16'h0022);
    wait_halted("install", 20);
    @(negedge clk);
    checks++;
    if (out_q.size() != 1 || out_q[0] !== 16'h0033) begin
      errors++; $display("FAIL install_out: got n=%0d first=%h expected n=1 0033", out_q.size(), (out_q.size() > 0) ? out_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_datapath();
    do_reset();
    prog = '{mw(A_PASS, SH_NO,  R_IO, 4'd1, Q_NEXT, 0),
             mw(A_PASS, SH_ROL, 4'd1, R_IO, Q_NEXT, 0),
             mw(A_PASS, SH_ASR, 4'd1, R_IO, Q_NEXT, 0),
             mw(A_XOR,  SH_NO,  4'd1, R_IO, Q_NEXT, 0),
             mw(A_SUB,  SH_NO,  4'd1, R_IO, Q_NEXT, 0),
             mw(A_AND,  SH_NO,  4'd1, R_IO, Q_NEXT, 0),
             mw(A_PASS, SH_SHR, 4'd1, R_IO, Q_NEXT, 0),
             mw(A_ADD,  SH_NO,  R_ZERO, R_ZERO, Q_HALT, 0)};
    load_prog();
    din_q = '{16'h8001};
    pulse_start();
    wait_halted("dp", 30);
    @(negedge clk);
    begin
      logic [15:0] exp_v [6] = '{16'h0003, 16'hC000, 16'h4001, 16'hC000, 16'h8000, 16'h4000};
      checks++;
      if (out_q.size() != 6) begin
        errors++; $display("FAIL dp_count: got %0d expected 6", out_q.size());
      end else begin
        for (int i = 0; i < 6; i++) begin
          checks++;
          if (out_q[i] !== exp_v[i]) begin errors++; $display("FAIL dp_out%0d: got %h expected %h", i, out_q[i], exp_v[i]); end
        end
      end
    end
    checks++;
    if ({flag_z, flag_c} !== 2'b00) begin errors++; $display("FAIL dp_flags: z/c=%b expected 00", {flag_z, flag_c}); end
  endtask

  task automatic run_loop(input string name);
    int n = 0;
    while (out_q.size() < 4 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (out_q.size() < 4) begin
      errors++; $display("FAIL %s_timeout: got %0d outputs expected 4", name, out_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_q[i] !== 16'(i + 1)) begin errors++; $display("FAIL %s_out%0d: got %h expected %h", name, i, out_q[i], 16'(i + 1)); end
      end
    end
  endtask

  task automatic test_rst_midloop();
    do_reset();
    prog = '{mw(A_PASS, SH_NO, R_ZERO, 4'd0, Q_NEXT, 0),
             mw(A_INC,  SH_NO, 4'd0, 4'd0, Q_NEXT, 0),
             mw(A_PASS, SH_NO, 4'd0, R_IO, Q_JMP, 8'd1)};
    load_prog();
    pulse_start();
    run_loop("loop1");
    rst = 1;
    #1;
    checks++;
    if ({din_ready, dout_valid, busy, halted, err, flag_z, flag_c} !== 7'b0 || dout !== 16'h0000) begin
      errors++; $display("FAIL midrst_outputs: flags=%b dout=%h expected 0000000 0000",
                         {din_ready, dout_valid, busy, halted, err, flag_z, flag_c}, dout);
    end
    @(negedge clk);
    rst = 0;
    out_q.delete();
    pulse_start();
    run_loop("loop2");
  endtask

  task automatic test_nested_call();
    int exp_err, exp_n;
    do_reset();
    prog = '{mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_CALL, 8'd1),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_CALL, 8'd2),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_CALL, 8'd3),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_CALL, 8'd4),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_CALL, 8'd5),
             mw(A_PASS, SH_NO, R_ZERO, R_IO, Q_HALT, 0)};
    load_prog();
`ifdef MICRO_STACK_EN
    exp_err = 1; exp_n = 0;
`else
    exp_err = 0; exp_n = 1;
`endif
    pulse_start();
    wait_halted("call", 20);
    @(negedge clk);
    checks++;
    if (err !== exp_err[0] || out_q.size() != exp_n) begin
      errors++; $display("FAIL call_nest: err=%b outs=%0d expected err=%0d outs=%0d", err, out_q.size(), exp_err, exp_n);
    end
    prog = '{mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_HALT, 0)};
    load_prog();
    pulse_start();
    checks++;
    if ({busy, err} !== 2'b10) begin errors++; $display("FAIL call_errclr: busy/err=%b expected 10", {busy, err}); end
    wait_halted("errclr", 10);
  endtask

  task automatic test_call_ret();
    do_reset();
    prog = '{mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_CALL, 8'd3),
             mw(A_NOT, SH_NO, R_ZERO, R_IO, Q_NEXT, 0),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_HALT, 0),
             mw(A_ADD, SH_NO, R_ZERO, R_ZERO, Q_RET, 0)};
    load_prog();
    pulse_start();
    wait_halted("ret", 20);
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || out_q.size() != 1 || out_q[0] !== 16'hFFFF) begin
      errors++; $display("FAIL call_ret: err=%b outs=%0d expected err=0 one ffff", err, out_q.size());
    end
  endtask

  initial begin
    rst = 1; start = 0; uc_we = 0; uc_addr = '0; uc_wdata = '0; dout_ready = 1;
    test_reset();
    test_add();
    test_carry_jump();
    test_out_stall();
    test_in_stall();
    test_datapath();
    test_rst_midloop();
    test_nested_call();
    test_call_ret();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
